// File: rtl/pc_unit_param_if.sv
// ============================================================================
//  Module      : pc_unit_param_if
//  Description : Control/status bundle between the control unit, ALU flag and
//                instruction memory on one side and the PC unit on the other.
//                master : drives control inputs, observes PC and RAS status
//                slave  : the PC unit itself
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_unit_param_if #(
    parameter int ADDR_W = 32
);
    // control inputs to the PC unit
    logic              stall;
    logic              SaltoCond;
    logic              br_ne;
    logic              oZero;
    logic [ADDR_W-1:0] extSigno;
    logic              jmp_en;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] jmp_target;
    // status / address outputs from the PC unit
    logic [ADDR_W-1:0] direinstru;
    logic [ADDR_W-1:0] pc_next;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_ovf;
    logic              ras_unf;

    modport master (
        output stall, SaltoCond, br_ne, oZero, extSigno,
               jmp_en, call, ret, jmp_target,
        input  direinstru, pc_next, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, SaltoCond, br_ne, oZero, extSigno,
               jmp_en, call, ret, jmp_target,
        output direinstru, pc_next, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

`default_nettype wire

// File: rtl/pc_unit_param.sv
// ============================================================================
//  Module      : pc_unit_param
//  Description : Parametrised program counter with conditional branch,
//                absolute jump, call/return and a circular return-address
//                stack (RAS).
//  Ports       : clk   - system clock, rising edge
//                reset - asynchronous active-high reset
//                bus   - pc_unit_param_if.slave (controls, PC, RAS status)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit_param #(
    parameter int                ADDR_W    = 32,
    parameter int                STEP      = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pc_unit_param_if.slave     bus
);

    localparam int                 c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0]  c_STEP  = ADDR_W'(STEP);
    localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_1 = c_CNT_W'(1);

    // state
    logic [ADDR_W-1:0]  r_pc_q;
    logic [ADDR_W-1:0]  r_ras_q [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_ptr_q;    // next write slot; top entry is r_ptr_q-1
    logic [c_CNT_W-1:0] r_cnt_q;
    logic               r_ovf_q;
    logic               r_unf_q;

    // next state
    logic [ADDR_W-1:0]  w_pc_d;
    logic [ADDR_W-1:0]  w_ras_d [RAS_DEPTH];
    logic [c_PTR_W-1:0] w_ptr_d;
    logic [c_CNT_W-1:0] w_cnt_d;
    logic               w_ovf_d;
    logic               w_unf_d;

    // datapath
    logic [ADDR_W-1:0]  w_seq;
    logic [ADDR_W-1:0]  w_btgt;
    logic [ADDR_W-1:0]  w_top;
    logic [ADDR_W-1:0]  w_pc_next;
    logic               w_taken;
    logic               w_empty;
    logic               w_full;

    always_comb begin
        w_seq   = r_pc_q + c_STEP;
        w_btgt  = w_seq + bus.extSigno;
        w_taken = bus.SaltoCond & (bus.oZero ^ bus.br_ne);
        w_empty = (r_cnt_q == '0);
        w_full  = (r_cnt_q == c_DEPTH);
        w_top   = r_ras_q[r_ptr_q - c_PTR_1];

        // ret > call/jmp > branch > sequential
        if (bus.ret)
            w_pc_next = w_empty ? w_seq : w_top;
        else if (bus.call || bus.jmp_en)
            w_pc_next = bus.jmp_target;
        else if (w_taken)
            w_pc_next = w_btgt;
        else
            w_pc_next = w_seq;
    end

    always_comb begin
        w_pc_d  = r_pc_q;
        w_ras_d = r_ras_q;
        w_ptr_d = r_ptr_q;
        w_cnt_d = r_cnt_q;
        w_ovf_d = r_ovf_q;
        w_unf_d = r_unf_q;

        if (!bus.stall) begin
            w_pc_d = w_pc_next;
            if (bus.ret) begin
                // a simultaneous call is dropped: no push
                if (!w_empty) begin
                    w_ptr_d = r_ptr_q - c_PTR_1;
                    w_cnt_d = r_cnt_q - c_CNT_1;
                end else begin
                    w_unf_d = 1'b1;
                end
            end else if (bus.call) begin
                // when full, r_ptr_q points at the oldest entry, so the
                // write naturally overwrites it circularly
                w_ras_d[r_ptr_q] = w_seq;
                w_ptr_d          = r_ptr_q + c_PTR_1;
                if (w_full)
                    w_ovf_d = 1'b1;
                else
                    w_cnt_d = r_cnt_q + c_CNT_1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_q  <= RESET_VEC;
            r_ptr_q <= '0;
            r_cnt_q <= '0;
            r_ovf_q <= 1'b0;
            r_unf_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++)
                r_ras_q[i] <= '0;
        end else begin
            r_pc_q  <= w_pc_d;
            r_ptr_q <= w_ptr_d;
            r_cnt_q <= w_cnt_d;
            r_ovf_q <= w_ovf_d;
            r_unf_q <= w_unf_d;
            for (int i = 0; i < RAS_DEPTH; i++)
                r_ras_q[i] <= w_ras_d[i];
        end
    end

    assign bus.direinstru = r_pc_q;
    assign bus.pc_next    = w_pc_next;
    assign bus.ras_empty  = w_empty;
    assign bus.ras_full   = w_full;
    assign bus.ras_ovf    = r_ovf_q;
    assign bus.ras_unf    = r_unf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit_param.sv
// ============================================================================
//  Module      : tb_pc_unit_param
//  Description : Self-checking bench for pc_unit_param (32-bit main instance
//                with a 4-entry RAS, plus an 8-bit instance for wrap-around).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit_param;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    pc_unit_param_if #(.ADDR_W(32)) bus ();
    pc_unit_param_if #(.ADDR_W(8))  bus8 ();

    pc_unit_param #(
        .ADDR_W(32), .STEP(1), .RESET_VEC(32'd0), .RAS_DEPTH(4)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    pc_unit_param #(
        .ADDR_W(8), .STEP(1), .RESET_VEC(8'hFE), .RAS_DEPTH(4)
    ) u_dut8 (
        .clk(clk), .reset(reset), .bus(bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        salto;
        logic        br_ne;
        logic        ozero;
        logic [31:0] ext;
        logic        jmp;
        logic [31:0] tgt;
        logic [31:0] exp_next;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.SaltoCond = 0; bus.br_ne = 0; bus.oZero = 0;
        bus.extSigno = '0; bus.jmp_en = 0; bus.call = 0; bus.ret = 0;
        bus.jmp_target = '0;
    endtask

    task automatic do_jump(input logic [31:0] t);
        idle_inputs();
        bus.jmp_en = 1; bus.jmp_target = t;
        step();
        idle_inputs();
        chk("jump_setup", bus.direinstru, t);
    endtask

    task automatic do_call(input logic [31:0] t, input string name);
        idle_inputs();
        bus.call = 1; bus.jmp_target = t;
        step();
        idle_inputs();
        chk(name, bus.direinstru, t);
    endtask

    task automatic do_ret(input logic [31:0] exp, input string name);
        idle_inputs();
        bus.ret = 1;
        #1;
        chk({name, "_pc_next"}, bus.pc_next, exp);
        step();
        idle_inputs();
        chk(name, bus.direinstru, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus8.stall = 0; bus8.SaltoCond = 0; bus8.br_ne = 0; bus8.oZero = 0;
        bus8.extSigno = '0; bus8.jmp_en = 0; bus8.call = 0; bus8.ret = 0;
        bus8.jmp_target = '0;
        idle_inputs();

        // ---------------- reset and sequential stepping ----------------
        reset = 1;
        #12;
        chk("rst_pc", bus.direinstru, 32'd0);
        chk("rst_pc_next", bus.pc_next, 32'd1);
        chk("rst_empty", 32'(bus.ras_empty), 32'd1);
        chk("rst_full", 32'(bus.ras_full), 32'd0);
        chk("rst_ovf", 32'(bus.ras_ovf), 32'd0);
        chk("rst_unf", 32'(bus.ras_unf), 32'd0);
        chk("rst_pc8", 32'(bus8.direinstru), 32'hFE);
        @(negedge clk);
        reset = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq_pc", bus.direinstru, 32'(i));
            if (i == 1) chk("wrap8_ff", 32'(bus8.direinstru), 32'hFF);
            if (i == 2) chk("wrap8_00", 32'(bus8.direinstru), 32'h00);
        end
        // asynchronous reset pulse between edges
        #2;
        reset = 1;
        #1;
        chk("async_rst_pc", bus.direinstru, 32'd0);
        chk("async_rst_pc8", 32'(bus8.direinstru), 32'hFE);
        #1;
        reset = 0;

        // ---------------- table-driven branch / jump vectors -----------
        //            salto bne  z    ext           jmp tgt     next  pc
        vecs[0] = '{0, 0, 0, 32'd0,        1, 32'd10, 32'd10, 32'd10};
        vecs[1] = '{1, 0, 1, 32'hFFFF_FFFD, 0, 32'd0,  32'd8,  32'd8};
        vecs[2] = '{0, 0, 0, 32'd0,        1, 32'd10, 32'd10, 32'd10};
        vecs[3] = '{1, 0, 0, 32'hFFFF_FFFD, 0, 32'd0,  32'd11, 32'd11};
        vecs[4] = '{0, 0, 0, 32'd0,        1, 32'd10, 32'd10, 32'd10};
        vecs[5] = '{1, 1, 0, 32'hFFFF_FFFD, 0, 32'd0,  32'd8,  32'd8};
        vecs[6] = '{1, 1, 1, 32'hFFFF_FFFD, 0, 32'd0,  32'd9,  32'd9};
        vecs[7] = '{1, 0, 1, 32'hFFFF_FFFD, 1, 32'd50, 32'd50, 32'd50};
        vecs[8] = '{0, 0, 0, 32'd0,        0, 32'd0,  32'd51, 32'd51};
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            bus.SaltoCond  = vecs[i].salto;
            bus.br_ne      = vecs[i].br_ne;
            bus.oZero      = vecs[i].ozero;
            bus.extSigno   = vecs[i].ext;
            bus.jmp_en     = vecs[i].jmp;
            bus.jmp_target = vecs[i].tgt;
            #1;
            chk($sformatf("vec%0d_pc_next", i), bus.pc_next, vecs[i].exp_next);
            step();
            chk($sformatf("vec%0d_pc", i), bus.direinstru, vecs[i].exp_pc);
            chk($sformatf("vec%0d_empty", i), 32'(bus.ras_empty), 32'd1);
        end

        // ---------------- single call / return --------------------------
        do_jump(32'd5);
        do_call(32'd100, "call_pc");
        chk("call_empty", 32'(bus.ras_empty), 32'd0);
        chk("call_full", 32'(bus.ras_full), 32'd0);
        step(); step(); step();
        chk("pre_ret_pc", bus.direinstru, 32'd103);
        do_ret(32'd6, "ret_pc");
        chk("ret_empty", 32'(bus.ras_empty), 32'd1);

        // ---------------- nested calls past the RAS depth ---------------
        do_call(32'd300, "nest1");   // pushes 7
        do_call(32'd400, "nest2");   // pushes 301
        do_call(32'd500, "nest3");   // pushes 401
        do_call(32'd600, "nest4");   // pushes 501
        chk("nest4_full", 32'(bus.ras_full), 32'd1);
        chk("nest4_ovf", 32'(bus.ras_ovf), 32'd0);
        do_call(32'd700, "nest5");   // pushes 601, overwrites 7
        chk("nest5_full", 32'(bus.ras_full), 32'd1);
        chk("nest5_ovf", 32'(bus.ras_ovf), 32'd1);
        do_ret(32'd601, "unwind1");
        chk("unwind1_full", 32'(bus.ras_full), 32'd0);
        do_ret(32'd501, "unwind2");
        do_ret(32'd401, "unwind3");
        do_ret(32'd301, "unwind4");
        chk("unwind4_empty", 32'(bus.ras_empty), 32'd1);
        chk("unwind4_unf", 32'(bus.ras_unf), 32'd0);
        do_ret(32'd302, "unwind5");
        chk("unwind5_unf", 32'(bus.ras_unf), 32'd1);
        chk("ovf_sticky", 32'(bus.ras_ovf), 32'd1);

        // ---------------- stall ----------------------------------------
        idle_inputs();
        bus.stall = 1; bus.jmp_en = 1; bus.jmp_target = 32'd900;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", bus.direinstru, 32'd302);
            chk("stall_pc_next", bus.pc_next, 32'd900);
        end
        bus.stall = 0;
        step();
        chk("stall_release_pc", bus.direinstru, 32'd900);
        idle_inputs();

        // ---------------- call and ret together ------------------------
        do_jump(32'd39);
        do_call(32'd1000, "cr_setup");   // pushes 40
        idle_inputs();
        bus.call = 1; bus.ret = 1; bus.jmp_target = 32'd2000;
        #1;
        chk("callret_pc_next", bus.pc_next, 32'd40);
        step();
        idle_inputs();
        chk("callret_pc", bus.direinstru, 32'd40);
        chk("callret_empty", 32'(bus.ras_empty), 32'd1);
        do_ret(32'd41, "callret_nopush");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/pc_unit_param.md
Name: pc_unit_param

Overview:
- Parametrised program-counter unit for the monocycle processor; the next generation of the basic PC block.
- Holds the current instruction address and selects the next one: sequential, conditional branch (equal/not-equal), absolute jump, call and return.
- Calls and returns use an internal circular return-address stack (RAS).
- Sits between the control unit / ALU zero flag and the instruction memory address input.

Parameters:
ADDR_W, 32, width of PC, offset, target and RAS entries
STEP, 1, sequential increment (1 = word-addressed instruction memory)
RESET_VEC, 0, PC value after reset
RAS_DEPTH, 4, number of RAS entries (power of two, 2..16)

Ports:
clk  input  1  system clock, rising edge active
reset  input  1  asynchronous, active-high reset
stall  input  1  hold PC and RAS unchanged this cycle
SaltoCond  input  1  conditional-branch instruction decoded
br_ne  input  1  0 = branch on zero (beq), 1 = branch on not-zero (bne)
oZero  input  1  ALU zero flag
extSigno  input  ADDR_W  sign-extended branch offset, in instructions
jmp_en  input  1  absolute jump
call  input  1  jump to jmp_target and push return address
ret  input  1  pop RAS and jump to the popped address
jmp_target  input  ADDR_W  absolute jump/call target
direinstru  output  ADDR_W  registered current PC, drives instruction memory
pc_next  output  ADDR_W  combinational next-PC value
ras_empty  output  1  RAS holds 0 entries
ras_full  output  1  RAS holds RAS_DEPTH entries
ras_ovf  output  1  sticky: a call was made while RAS full
ras_unf  output  1  sticky: a ret was made while RAS empty

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- On reset assertion, immediately and regardless of clk:
  - direinstru = RESET_VEC
  - RAS count = 0, top pointer = 0, all RAS entries = 0
  - ras_ovf = 0, ras_unf = 0
  - ras_empty = 1, ras_full = 0
- Reset asserted mid-operation aborts any pending push/pop.
- After reset release, the first rising edge performs a normal update.
- Next-PC derivation:
  - seq = direinstru + STEP
  - taken = SaltoCond & (oZero XOR br_ne)
  - btgt = seq + extSigno
  - All arithmetic is modulo 2^ADDR_W; wrap-around is silent and flags nothing.
- pc_next selection, highest priority first:
  1. ret: RAS top if not empty, else seq
  2. call or jmp_en: jmp_target
  3. taken: btgt
  4. otherwise: seq
- pc_next is purely combinational. On each rising edge with stall=0: direinstru <= pc_next.
- stall=1: direinstru, RAS contents, pointer and count hold. Sticky flags do not set. pc_next is still driven.
- RAS push (call accepted, stall=0):
  - Writes seq, i.e. the address after the call.
  - If not full: count increments.
  - If full: the oldest entry is overwritten circularly, count stays RAS_DEPTH, ras_ovf <= 1.
- RAS pop (ret accepted, stall=0):
  - If not empty: count decrements and the pointer retreats.
  - If empty: no state change except ras_unf <= 1; PC takes seq.
- call and ret asserted together: ret wins; no push occurs; call is ignored.
- jmp_en together with call behaves as call. SaltoCond is ignored whenever ret, call or jmp_en is high.
- Sticky flags clear only on reset.
- Latency: one cycle from control inputs to the new direinstru. The RAS top is readable combinationally for ret in the same cycle.

Test Plan:
- Reset with RESET_VEC=0, then 4 idle edges -> direinstru 0,1,2,3,4; pulse reset asynchronously between edges -> direinstru=0 without a clock edge.
- PC=10, SaltoCond=1, br_ne=0, oZero=1, extSigno=-3 -> direinstru=8; same with oZero=0 -> 11; br_ne=1, oZero=0 -> 8.
- PC=5, call, jmp_target=100 -> PC=100, RAS count=1; ret at PC=103 -> PC=6, ras_empty=1.
- 5 nested calls with RAS_DEPTH=4 -> ras_full=1 and ras_ovf=1; 4 rets return the 4 newest addresses; 5th ret -> seq address and ras_unf=1.
- stall=1 for 3 edges with jmp_en=1 -> direinstru unchanged, pc_next=jmp_target; release -> jump taken; ADDR_W=8, PC=255, idle -> PC=0.
- call and ret together with RAS holding 40 -> PC=40, count decremented, no push.
